// File: rtl/apb_rr_master.sv
// APB master with round-robin arbitration. NUM_REQ requesters share a single
// APB slave. The slave has no pready, so a transfer always takes a fixed
// number of cycles. Read data is sampled in the cycle after ACCESS, which is
// when the slave presents prdata.
module apb_rr_master #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               winner_valid;
  logic [1:0]         rst_sync_reg;
  logic               rst_int_n;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  // Unpack the flat requester buses into per-requester arrays.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  // Round-robin pick: scan from farthest to nearest after the pointer, so
  // the last hit is the first requester following the previous winner.
  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    cand         = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (req[cand]) begin
        winner       = cand;
        winner_valid = 1'b1;
      end
    end
  end

  // Transfer sequencer. All bus and handshake outputs are registered here.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= IDX_W'(NUM_REQ - 1);
      owner_reg  <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state_reg)
        IDLE: begin
          if (winner_valid) begin
            paddr      <= addr_arr[winner];
            pwdata     <= wdata_arr[winner];
            pwrite     <= req_write[winner];
            psel       <= 1'b1;
            penable    <= 1'b0;
            gnt        <= ONE_HOT0 << winner;
            rr_ptr_reg <= winner;
            owner_reg  <= winner;
            state_reg  <= SETUP;
          end
        end
        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (pwrite) begin
            done      <= ONE_HOT0 << owner_reg;
            state_reg <= IDLE;
          end else begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata     <= prdata;
          done      <= ONE_HOT0 << owner_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed testbench for apb_rr_master with a behavioural APB slave memory.
module tb_apb_rr_master;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [31:0]  rdata;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;

  logic [31:0]  mem [256];

  int n_checks;
  int n_fail;

  apb_rr_master #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: writes land in ACCESS; read data appears in the following cycle.
  always @(posedge clk) begin
    if (psel && penable) begin
      if (pwrite) mem[paddr] <= pwdata;
      else        prdata     <= mem[paddr];
    end
  end

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F96;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // One transfer by requester r; returns req->done latency (-1 on timeout).
  task automatic do_xfer(input int r, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
    req_write[r]          = wr;
    req_addr[r*8 +: 8]    = a;
    req_wdata[r*32 +: 32] = d;
    req[r]                = 1'b1;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gnt[r]) req[r] = 1'b0;
      if (done[r]) begin
        lat = c;
        rd  = rdata;
        break;
      end
    end
    req[r] = 1'b0;
    $display("xfer req%0d %s addr=%h wdata=%h lat=%0d rdata=%h",
             r, wr ? "WR" : "RD", a, d, lat, rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++; if (psel !== 1'b0)    begin n_fail++; $display("FAIL reset_psel got %b want 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable got %b want 0", penable); end
    n_checks++; if (pwrite !== 1'b0)  begin n_fail++; $display("FAIL reset_pwrite got %b want 0", pwrite); end
    n_checks++; if (gnt !== 4'h0)     begin n_fail++; $display("FAIL reset_gnt got %h want 0", gnt); end
    n_checks++; if (done !== 4'h0)    begin n_fail++; $display("FAIL reset_done got %h want 0", done); end
    n_checks++; if (paddr !== 8'h00)  begin n_fail++; $display("FAIL reset_paddr got %h want 0", paddr); end
    n_checks++; if (pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_pwdata got %h want 0", pwdata); end
    n_checks++; if (rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (psel !== 1'b0)    begin n_fail++; $display("FAIL idle_psel got %b want 0", psel); end
    $display("reset applied and released");
  endtask

  task automatic test_basic_write();
    req_write[0]    = 1'b1;
    req_addr[7:0]   = 8'h10;
    req_wdata[31:0] = 32'hDEAD_BEEF;
    req[0]          = 1'b1;
    tick();  // SETUP
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL bw_gnt got %b want 0001", gnt); end
    n_checks++; if ({psel, penable} !== 2'b10) begin n_fail++; $display("FAIL bw_setup got %b want 10", {psel, penable}); end
    n_checks++; if (paddr !== 8'h10) begin n_fail++; $display("FAIL bw_paddr got %h want 10", paddr); end
    n_checks++; if (pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bw_pwdata got %h want deadbeef", pwdata); end
    n_checks++; if (pwrite !== 1'b1) begin n_fail++; $display("FAIL bw_pwrite got %b want 1", pwrite); end
    req[0] = 1'b0;
    tick();  // ACCESS
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL bw_access got %b want 11", {psel, penable}); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL bw_gnt_pulse got %b want 0000", gnt); end
    n_checks++; if (paddr !== 8'h10) begin n_fail++; $display("FAIL bw_paddr_hold got %h want 10", paddr); end
    tick();  // back to IDLE, done visible
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL bw_done got %b want 0001", done); end
    n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL bw_idle got %b want 00", {psel, penable}); end
    tick();
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL bw_done_pulse got %b want 0000", done); end
    n_checks++; if (mem[8'h10] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bw_slave_mem got %h want deadbeef", mem[8'h10]); end
    $display("xfer req0 WR addr=10 wdata=deadbeef (phase-checked)");
  endtask

  task automatic test_read();
    int lat;
    logic [31:0] rd;
    do_xfer(2, 1'b0, 8'h10, 32'h0, lat, rd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency got %0d want 4", lat); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
    do_xfer(0, 1'b1, 8'h44, 32'h1234_5678, lat, rd);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_kept_on_write got %h want deadbeef", rd); end
  endtask

  task automatic test_rotation();
    int order[$];
    bit overlap;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_write[i]          = 1'b1;
      req_addr[i*8 +: 8]    = 8'(i);
      req_wdata[i*32 +: 32] = 32'h100 + 32'(i);
    end
    overlap = 1'b0;
    req = 4'hF;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      if (gnt != 4'h0) begin
        if (!$onehot(gnt)) overlap = 1'b1;
        order.push_back($clog2(gnt));
      end
      if ($countones(done) > 1) overlap = 1'b1;
    end
    req = 4'h0;
    repeat (6) begin
      tick();
      if ($countones(done) > 1 || $countones(gnt) > 1) overlap = 1'b1;
    end
    n_checks++; if (order.size() !== 5) begin n_fail++; $display("FAIL rot_count got %0d want 5", order.size()); end
    for (int k = 0; k < 5; k++) begin
      int got;
      got = (k < order.size()) ? order[k] : -1;
      n_checks++; if (got !== k % 4) begin n_fail++; $display("FAIL rot_order[%0d] got %0d want %0d", k, got, k % 4); end
    end
    n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL rot_onehot got overlap=%b want 0", overlap); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL rot_mem[%0d] got %h want %h", i, mem[i], 32'h100 + 32'(i)); end
    end
    $display("rotation grants observed: %0d", order.size());
  endtask

  task automatic test_priority();
    int lat;
    logic [31:0] rd;
    int order[$];
    do_xfer(1, 1'b1, 8'h20, 32'h11, lat, rd);  // pointer now at 1
    req_write[1] = 1'b1; req_addr[15:8]  = 8'h21; req_wdata[63:32]  = 32'h21;
    req_write[3] = 1'b1; req_addr[31:24] = 8'h23; req_wdata[127:96] = 32'h23;
    req = 4'b1010;
    for (int c = 0; c < 30 && order.size() < 2; c++) begin
      tick();
      if (gnt[1]) begin order.push_back(1); req[1] = 1'b0; end
      if (gnt[3]) begin order.push_back(3); req[3] = 1'b0; end
    end
    req = 4'h0;
    repeat (5) tick();
    n_checks++; if (order.size() !== 2) begin n_fail++; $display("FAIL prio_count got %0d want 2", order.size()); end
    n_checks++; if (order.size() < 1 || order[0] !== 3) begin n_fail++; $display("FAIL prio_first got %0d want 3", (order.size() > 0) ? order[0] : -1); end
    n_checks++; if (order.size() < 2 || order[1] !== 1) begin n_fail++; $display("FAIL prio_second got %0d want 1", (order.size() > 1) ? order[1] : -1); end
    $display("priority test grants observed: %0d", order.size());
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    int bad_lat;
    bad_lat = 0;
    for (int i = 0; i < 256; i++) begin
      do_xfer(0, 1'b1, 8'(i), pat(i), lat, rd);
      if (lat != 3) bad_lat++;
    end
    n_checks++; if (bad_lat !== 0) begin n_fail++; $display("FAIL b2b_wr_latency got %0d bad want 0", bad_lat); end
    for (int i = 0; i < 256; i++) begin
      do_xfer(1, 1'b0, 8'(i), 32'h0, lat, rd);
      n_checks++; if (rd !== pat(i) || lat !== 4) begin n_fail++; $display("FAIL b2b_rd[%0d] got %h lat %0d want %h lat 4", i, rd, lat, pat(i)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    bit stray;
    req_write[2]      = 1'b0;
    req_addr[23:16]   = 8'h10;
    req[2]            = 1'b1;
    tick();  // SETUP
    req[2] = 1'b0;
    tick();  // ACCESS
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL mid_in_access got %b want 11", {psel, penable}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (psel !== 1'b0)    begin n_fail++; $display("FAIL mid_psel got %b want 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL mid_penable got %b want 0", penable); end
    n_checks++; if (done !== 4'h0)    begin n_fail++; $display("FAIL mid_done got %h want 0", done); end
    n_checks++; if (rdata !== 32'h0)  begin n_fail++; $display("FAIL mid_rdata got %h want 0", rdata); end
    repeat (2) tick();
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (8) begin
      tick();
      if (done != 4'h0 || psel != 1'b0) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got stray=%b want 0", stray); end
    $display("reset asserted during read ACCESS");
    do_xfer(2, 1'b0, 8'h10, 32'h0, lat, rd);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL mid_recover_lat got %0d want 4", lat); end
    n_checks++; if (rd !== pat(16)) begin n_fail++; $display("FAIL mid_recover_data got %h want %h", rd, pat(16)); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_basic_write();
    test_read();
    test_rotation();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
